// File: rtl/ysyx_22050078_pipe_ctrl_if.sv
// Hazard-controller bundle: ID operand usage, EX destination/load flags, redirect,
// LSU busy, and the stage-register controls plus statistics returned by the controller.
interface ysyx_22050078_pipe_ctrl_if #(
    parameter int REG_ADDRW = 5,
    parameter int CNT_W     = 32
);
    logic [REG_ADDRW-1:0] i_id_rs1_addr;
    logic [REG_ADDRW-1:0] i_id_rs2_addr;
    logic                 i_id_rs1_ren;
    logic                 i_id_rs2_ren;
    logic                 i_id_st_en;
    logic [REG_ADDRW-1:0] i_ex_rd_addr;
    logic                 i_ex_rdwen;
    logic                 i_ex_ld_en;
    logic                 i_ex_jump;
    logic                 i_ls_busy;

    logic                 o_pc_wen;
    logic                 o_ifid_wen;
    logic                 o_idex_wen;
    logic                 o_exls_wen;
    logic                 o_ifid_flush;
    logic                 o_idex_bubble;
    logic                 o_id_ldstbp;
    logic                 o_hang;
    logic [CNT_W-1:0]     o_cnt_stall;
    logic [CNT_W-1:0]     o_cnt_bubble;
    logic [CNT_W-1:0]     o_cnt_flush;

    modport master (
        output i_id_rs1_addr, i_id_rs2_addr, i_id_rs1_ren, i_id_rs2_ren, i_id_st_en,
               i_ex_rd_addr, i_ex_rdwen, i_ex_ld_en, i_ex_jump, i_ls_busy,
        input  o_pc_wen, o_ifid_wen, o_idex_wen, o_exls_wen, o_ifid_flush,
               o_idex_bubble, o_id_ldstbp, o_hang, o_cnt_stall, o_cnt_bubble, o_cnt_flush
    );

    modport slave (
        input  i_id_rs1_addr, i_id_rs2_addr, i_id_rs1_ren, i_id_rs2_ren, i_id_st_en,
               i_ex_rd_addr, i_ex_rdwen, i_ex_ld_en, i_ex_jump, i_ls_busy,
        output o_pc_wen, o_ifid_wen, o_idex_wen, o_exls_wen, o_ifid_flush,
               o_idex_bubble, o_id_ldstbp, o_hang, o_cnt_stall, o_cnt_bubble, o_cnt_flush
    );
endinterface

// File: rtl/ysyx_22050078_pipe_ctrl.sv
// Pipeline hazard controller: load-use bubbles, redirect flushes, LSU freeze,
// memory-wait watchdog and saturating hazard statistics.
module ysyx_22050078_pipe_ctrl #(
    parameter int REG_ADDRW = 5,
    parameter int CNT_W     = 32,
    parameter int TIMEOUT   = 1024
) (
    input  logic                       clk,
    input  logic                       rst_n,
    ysyx_22050078_pipe_ctrl_if.slave   bus
);
    localparam int WCNT_W = $clog2(TIMEOUT);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);
    localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_WAIT = 2'd1,
        S_HANG = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic [CNT_W-1:0]    cnt_stall_q, cnt_stall_d;
    logic [CNT_W-1:0]    cnt_bubble_q, cnt_bubble_d;
    logic [CNT_W-1:0]    cnt_flush_q, cnt_flush_d;

    logic [REG_ADDRW-1:0] rs1_addr, rs2_addr, rd_addr;
    logic                 ex_ld, hz1, hz2, lu, freeze;

    assign rs1_addr = bus.i_id_rs1_addr;
    assign rs2_addr = bus.i_id_rs2_addr;
    assign rd_addr  = bus.i_ex_rd_addr;

    always_comb begin
        ex_ld  = bus.i_ex_ld_en & bus.i_ex_rdwen & (rd_addr != '0);
        hz1    = ex_ld & bus.i_id_rs1_ren & (rs1_addr == rd_addr);
        hz2    = ex_ld & bus.i_id_rs2_ren & (rs2_addr == rd_addr);
        lu     = hz1 | (hz2 & ~bus.i_id_st_en);
        freeze = bus.i_ls_busy | (state_q == S_HANG);
    end

    // Stage controls: freeze beats redirect, redirect beats load-use.
    always_comb begin
        bus.o_pc_wen      = 1'b1;
        bus.o_ifid_wen    = 1'b1;
        bus.o_idex_wen    = 1'b1;
        bus.o_exls_wen    = 1'b1;
        bus.o_ifid_flush  = 1'b0;
        bus.o_idex_bubble = 1'b0;
        bus.o_id_ldstbp   = hz2 & bus.i_id_st_en & ~hz1 & ~freeze;
        bus.o_hang        = (state_q == S_HANG);
        if (freeze) begin
            bus.o_pc_wen   = 1'b0;
            bus.o_ifid_wen = 1'b0;
            bus.o_idex_wen = 1'b0;
            bus.o_exls_wen = 1'b0;
        end else if (bus.i_ex_jump) begin
            bus.o_ifid_flush  = 1'b1;
            bus.o_idex_bubble = 1'b1;
        end else if (lu) begin
            bus.o_pc_wen      = 1'b0;
            bus.o_ifid_wen    = 1'b0;
            bus.o_idex_bubble = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        unique case (state_q)
            S_RUN: begin
                if (bus.i_ls_busy) begin
                    state_d = S_WAIT;
                    wcnt_d  = WCNT_ONE;
                end
            end
            S_WAIT: begin
                if (!bus.i_ls_busy) begin
                    state_d = S_RUN;
                    wcnt_d  = '0;
                end else if (wcnt_q == WCNT_LAST) begin
                    state_d = S_HANG;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            S_HANG:  state_d = S_HANG;
            default: begin
                state_d = S_RUN;
                wcnt_d  = '0;
            end
        endcase
    end

    always_comb begin
        cnt_stall_d  = cnt_stall_q;
        cnt_bubble_d = cnt_bubble_q;
        cnt_flush_d  = cnt_flush_q;
        if (freeze) begin
            if (cnt_stall_q != '1) cnt_stall_d = cnt_stall_q + 1'b1;
        end else if (bus.i_ex_jump) begin
            if (cnt_flush_q != '1) cnt_flush_d = cnt_flush_q + 1'b1;
        end else if (lu) begin
            if (cnt_bubble_q != '1) cnt_bubble_d = cnt_bubble_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_RUN;
            wcnt_q       <= '0;
            cnt_stall_q  <= '0;
            cnt_bubble_q <= '0;
            cnt_flush_q  <= '0;
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            cnt_stall_q  <= cnt_stall_d;
            cnt_bubble_q <= cnt_bubble_d;
            cnt_flush_q  <= cnt_flush_d;
        end
    end

    assign bus.o_cnt_stall  = cnt_stall_q;
    assign bus.o_cnt_bubble = cnt_bubble_q;
    assign bus.o_cnt_flush  = cnt_flush_q;
endmodule

// File: tb/tb_ysyx_22050078_pipe_ctrl.sv
// Bench for the hazard controller: directed scenarios with fixed expectations plus
// randomized traffic against a cycle-level behavioural model.
module tb_ysyx_22050078_pipe_ctrl;
    localparam int AW = 5;
    localparam int CW = 4;
    localparam int TO = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ysyx_22050078_pipe_ctrl_if #(.REG_ADDRW(AW), .CNT_W(CW)) bus ();

    ysyx_22050078_pipe_ctrl #(.REG_ADDRW(AW), .CNT_W(CW), .TIMEOUT(TO)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // {pc, ifid, idex, exls, flush, bubble, ldstbp, hang}
    logic [7:0]      got;
    logic [3*CW-1:0] cnts;
    assign got  = {bus.o_pc_wen, bus.o_ifid_wen, bus.o_idex_wen, bus.o_exls_wen,
                   bus.o_ifid_flush, bus.o_idex_bubble, bus.o_id_ldstbp, bus.o_hang};
    assign cnts = {bus.o_cnt_stall, bus.o_cnt_bubble, bus.o_cnt_flush};

    int n_cmp = 0;
    int n_err = 0;

    int m_stall, m_bubble, m_flush, m_run;
    bit m_hang;

    function automatic void model_clear();
        m_stall = 0; m_bubble = 0; m_flush = 0; m_run = 0; m_hang = 0;
    endfunction

    function automatic bit model_loaduse(output bit st_bypass);
        bit ex_has_load, need1, need2;
        ex_has_load = bus.i_ex_ld_en && bus.i_ex_rdwen && (bus.i_ex_rd_addr != 0);
        need1 = ex_has_load && bus.i_id_rs1_ren && (bus.i_id_rs1_addr == bus.i_ex_rd_addr);
        need2 = ex_has_load && bus.i_id_rs2_ren && (bus.i_id_rs2_addr == bus.i_ex_rd_addr);
        st_bypass = need2 && bus.i_id_st_en && !need1;
        return need1 || (need2 && !bus.i_id_st_en);
    endfunction

    function automatic logic [7:0] model_ctrl();
        bit frz, lu, byp;
        frz = bus.i_ls_busy || m_hang;
        lu  = model_loaduse(byp);
        if (frz)                return {7'b0000000, m_hang};
        else if (bus.i_ex_jump) return {6'b111111, byp, 1'b0};
        else if (lu)            return {8'b00110100};
        else                    return {6'b111100, byp, 1'b0};
    endfunction

    function automatic logic [3*CW-1:0] model_cnts();
        return {CW'(m_stall), CW'(m_bubble), CW'(m_flush)};
    endfunction

    function automatic void model_edge();
        bit byp, lu;
        lu = model_loaduse(byp);
        if (bus.i_ls_busy || m_hang) begin
            if (m_stall < CMAX) m_stall++;
        end else if (bus.i_ex_jump) begin
            if (m_flush < CMAX) m_flush++;
        end else if (lu) begin
            if (m_bubble < CMAX) m_bubble++;
        end
        if (!m_hang) begin
            if (bus.i_ls_busy) begin
                m_run++;
                if (m_run >= TO) m_hang = 1;
            end else begin
                m_run = 0;
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_in(input int rs1, input int rs2, input bit r1en, input bit r2en,
                          input bit st, input int rd, input bit rdwen, input bit ld,
                          input bit jump, input bit busy);
        bus.i_id_rs1_addr = AW'(rs1);
        bus.i_id_rs2_addr = AW'(rs2);
        bus.i_id_rs1_ren  = r1en;
        bus.i_id_rs2_ren  = r2en;
        bus.i_id_st_en    = st;
        bus.i_ex_rd_addr  = AW'(rd);
        bus.i_ex_rdwen    = rdwen;
        bus.i_ex_ld_en    = ld;
        bus.i_ex_jump     = jump;
        bus.i_ls_busy     = busy;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        n_cmp++;
        if (got !== 8'hF0) begin n_err++; $display("FAIL reset_ctrl: got %h expected %h", got, 8'hF0); end
        n_cmp++;
        if (cnts !== '0) begin n_err++; $display("FAIL reset_cnts: got %h expected %h", cnts, 12'h000); end
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        n_cmp++;
        if (got !== 8'h00) begin n_err++; $display("FAIL reset_busy_comb: got %h expected %h", got, 8'h00); end
        do_reset();
    endtask

    task automatic test_load_use();
        do_reset();
        set_in(5, 7, 1, 1, 0, 5, 1, 1, 0, 0);
        n_cmp++;
        if (got !== 8'h34) begin n_err++; $display("FAIL lu_rs1: got %h expected %h", got, 8'h34); end
        tick();
        set_in(6, 7, 1, 1, 0, 0, 0, 0, 0, 0);
        n_cmp++;
        if (got !== 8'hF0) begin n_err++; $display("FAIL lu_after: got %h expected %h", got, 8'hF0); end
        tick();
        n_cmp++;
        if (cnts !== 12'h010) begin n_err++; $display("FAIL lu_cnt: got %h expected %h", cnts, 12'h010); end
    endtask

    task automatic test_ldst_bypass();
        do_reset();
        set_in(8, 5, 1, 1, 1, 5, 1, 1, 0, 0);
        n_cmp++;
        if (got !== 8'hF2) begin n_err++; $display("FAIL ldst_data: got %h expected %h", got, 8'hF2); end
        set_in(5, 9, 1, 1, 1, 5, 1, 1, 0, 0);
        n_cmp++;
        if (got !== 8'h34) begin n_err++; $display("FAIL ldst_addr: got %h expected %h", got, 8'h34); end
        set_in(5, 5, 1, 1, 1, 5, 1, 1, 0, 0);
        n_cmp++;
        if (got !== 8'h34) begin n_err++; $display("FAIL ldst_both: got %h expected %h", got, 8'h34); end
        set_in(8, 5, 1, 1, 1, 5, 1, 1, 0, 1);
        n_cmp++;
        if (got !== 8'h00) begin n_err++; $display("FAIL ldst_frozen: got %h expected %h", got, 8'h00); end
    endtask

    task automatic test_x0_nonload();
        do_reset();
        set_in(0, 0, 1, 1, 0, 0, 1, 1, 0, 0);
        n_cmp++;
        if (got !== 8'hF0) begin n_err++; $display("FAIL x0_load: got %h expected %h", got, 8'hF0); end
        set_in(5, 5, 1, 1, 0, 5, 1, 0, 0, 0);
        n_cmp++;
        if (got !== 8'hF0) begin n_err++; $display("FAIL nonload: got %h expected %h", got, 8'hF0); end
        set_in(5, 5, 0, 0, 0, 5, 1, 1, 0, 0);
        n_cmp++;
        if (got !== 8'hF0) begin n_err++; $display("FAIL no_ren: got %h expected %h", got, 8'hF0); end
    endtask

    task automatic test_redirect_lu();
        do_reset();
        set_in(5, 7, 1, 1, 0, 5, 1, 1, 1, 0);
        n_cmp++;
        if (got !== 8'hFC) begin n_err++; $display("FAIL redir_lu: got %h expected %h", got, 8'hFC); end
        tick();
        n_cmp++;
        if (cnts !== 12'h001) begin n_err++; $display("FAIL redir_cnt: got %h expected %h", cnts, 12'h001); end
    endtask

    task automatic test_busy_jump();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(1, 2, 1, 1, 0, 3, 1, 0, 1, 1);
            n_cmp++;
            if (got !== 8'h00) begin n_err++; $display("FAIL busy_jump_c%0d: got %h expected %h", i, got, 8'h00); end
            tick();
        end
        set_in(1, 2, 1, 1, 0, 3, 1, 0, 1, 0);
        n_cmp++;
        if (got !== 8'hFC) begin n_err++; $display("FAIL busy_jump_release: got %h expected %h", got, 8'hFC); end
        tick();
        n_cmp++;
        if (cnts !== 12'h301) begin n_err++; $display("FAIL busy_jump_cnt: got %h expected %h", cnts, 12'h301); end
    endtask

    task automatic test_watchdog();
        do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_cmp++;
            if (got !== 8'h00) begin n_err++; $display("FAIL wd_pre%0d: got %h expected %h", i, got, 8'h00); end
        end
        tick();
        n_cmp++;
        if (got !== 8'h01) begin n_err++; $display("FAIL wd_hang: got %h expected %h", got, 8'h01); end
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        n_cmp++;
        if (got !== 8'h01) begin n_err++; $display("FAIL wd_sticky: got %h expected %h", got, 8'h01); end
        tick();
        n_cmp++;
        if (got !== 8'h01) begin n_err++; $display("FAIL wd_sticky2: got %h expected %h", got, 8'h01); end
        n_cmp++;
        if (cnts !== 12'h500) begin n_err++; $display("FAIL wd_cnt: got %h expected %h", cnts, 12'h500); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (got !== 8'hFC) begin n_err++; $display("FAIL wd_async_clr: got %h expected %h", got, 8'hFC); end
        rst_n = 1'b1;
        model_clear();
        // Reset released mid-WAIT: the busy run restarts from zero.
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        repeat (3) tick();
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        model_clear();
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_cmp++;
            if (got !== 8'h00) begin n_err++; $display("FAIL wd_rewait%0d: got %h expected %h", i, got, 8'h00); end
        end
        tick();
        n_cmp++;
        if (got !== 8'h01) begin n_err++; $display("FAIL wd_rehang: got %h expected %h", got, 8'h01); end
    endtask

    task automatic test_random();
        logic [7:0]      exp_c;
        logic [3*CW-1:0] exp_n;
        bit busy;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            busy = ($urandom_range(0, 4) == 0) && (m_run < TO - 1);
            set_in($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
                   $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
                   $urandom_range(0, 1), $urandom_range(0, 1), ($urandom_range(0, 3) == 0), busy);
            exp_c = model_ctrl();
            n_cmp++;
            if (got !== exp_c) begin n_err++; $display("FAIL rand_ctrl[%0d]: got %h expected %h", i, got, exp_c); end
            tick();
            exp_n = model_cnts();
            n_cmp++;
            if (cnts !== exp_n) begin n_err++; $display("FAIL rand_cnt[%0d]: got %h expected %h", i, cnts, exp_n); end
        end
        n_cmp++;
        if (cnts !== 12'hFFF && m_stall == CMAX && m_bubble == CMAX && m_flush == CMAX)
            begin n_err++; $display("FAIL rand_saturate: got %h expected %h", cnts, 12'hFFF); end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_load_use();
        test_ldst_bypass();
        test_x0_nonload();
        test_redirect_lu();
        test_busy_jump();
        test_watchdog();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ysyx_22050078_pipe_ctrl.md
# ysyx_22050078_pipe_ctrl

Pipeline hazard controller that drives the stage-register control inputs of the 5-stage core. It issues the ID/EX bubble request and the stall, flush and write-enable controls for PC, IF/ID, ID/EX and EX/LS. Inputs are the ID-stage operand usage, the ID/EX register outputs (EX-stage destination and load flags), the EXU redirect and the LSU busy flag. It also keeps a memory-wait watchdog and saturating hazard counters for simulation statistics.

## Interface
- `REG_ADDRW`, default 5: register address width.
- `CNT_W`, default 32: width of each statistics counter.
- `TIMEOUT`, default 1024: consecutive busy cycles after which the block declares a hang. Must be at least 2.

Ports:
- `clk` input, 1 bit: clock, rising edge.
- `rst_n` input, 1 bit: reset, asynchronous, active-low.
- `i_id_rs1_addr`, `i_id_rs2_addr` input, REG_ADDRW each: ID source register addresses.
- `i_id_rs1_ren`, `i_id_rs2_ren` input, 1 bit each: ID actually reads rs1 / rs2.
- `i_id_st_en` input, 1 bit: the ID instruction is a store.
- `i_ex_rd_addr` input, REG_ADDRW: EX destination register address.
- `i_ex_rdwen`, `i_ex_ld_en` input, 1 bit each: EX writes rd / EX is a load.
- `i_ex_jump` input, 1 bit: EX resolved a taken branch or jump this cycle.
- `i_ls_busy` input, 1 bit: LSU access outstanding, so the pipeline must freeze.
- `o_pc_wen`, `o_ifid_wen`, `o_idex_wen`, `o_exls_wen` output, 1 bit each: stage-register write enables.
- `o_ifid_flush` output, 1 bit: load a NOP into IF/ID.
- `o_idex_bubble` output, 1 bit: feeds the ID/EX bubble input.
- `o_id_ldstbp` output, 1 bit: load-to-store-data bypass select, latched into ID/EX.
- `o_hang` output, 1 bit: sticky watchdog flag.
- `o_cnt_stall`, `o_cnt_bubble`, `o_cnt_flush` output, CNT_W each: statistics counters.

## Operation
Combinational hazard terms:
- `ex_ld = i_ex_ld_en & i_ex_rdwen & (i_ex_rd_addr != 0)`.
- `hz1 = ex_ld & i_id_rs1_ren & (i_id_rs1_addr == i_ex_rd_addr)`.
- `hz2 = ex_ld & i_id_rs2_ren & (i_id_rs2_addr == i_ex_rd_addr)`.
- Load-use `lu = hz1 | (hz2 & ~i_id_st_en)`.
- `o_id_ldstbp = hz2 & i_id_st_en & ~hz1 & ~freeze`. Store data is forwarded from the LS stage, so no bubble is needed.

FSM states: RUN, WAIT, HANG. `freeze` = `i_ls_busy` or state == HANG. A 2-bit state register plus a wait counter of width `clog2(TIMEOUT)` are required.

Output priority, highest first:
1. **freeze**: all four `*_wen` = 0, flush = 0, bubble = 0. A redirect or load-use condition present at the same time is held, not lost, because the EX and ID contents do not change.
2. **`i_ex_jump`**: all `*_wen` = 1, `o_ifid_flush` = 1, `o_idex_bubble` = 1. Redirect overrides load-use in the same cycle.
3. **lu**: `o_pc_wen` = 0, `o_ifid_wen` = 0, `o_idex_wen` = 1, `o_exls_wen` = 1, `o_idex_bubble` = 1.
4. Otherwise: all `*_wen` = 1, flush = 0, bubble = 0.

FSM transitions:
- RUN → WAIT on `i_ls_busy`. The wait counter loads 1.
- In WAIT, with `i_ls_busy` = 1: the counter increments. When the counter equals TIMEOUT−1 and busy is still 1, go to HANG.
- WAIT → RUN when `i_ls_busy` = 0. The counter clears.
- HANG is terminal until reset. `o_hang` = 1 and freeze is held regardless of `i_ls_busy`.

Counters saturate at all ones and do not wrap:
- `o_cnt_stall` counts cycles with freeze.
- `o_cnt_bubble` counts cycles with `lu` bubbles, excluding redirect.
- `o_cnt_flush` counts redirect cycles.

## Timing
- Reset (asynchronous, `rst_n` = 0): state RUN, wait counter 0, `o_hang` 0, all counters 0. The combinational outputs follow their inputs during reset.
- Deasserting reset mid-WAIT returns to RUN. A busy input that is still asserted re-enters WAIT one cycle later.
- All control outputs are combinational from the current-cycle inputs plus state, with zero latency. They must settle before the same rising edge that the stage registers sample.
- A load-use stall lasts exactly one cycle: after the edge, ID/EX holds a bubble and `i_ex_ld_en` becomes 0.
- Counters and FSM update on the rising edge. A counter increments on the edge that ends the counted cycle.
- `o_hang` rises on the edge at which the wait counter would have reached TIMEOUT, that is, after TIMEOUT consecutive busy cycles.

## Test plan
- **Load-use on rs1**: EX `lw x5`; ID `add x6,x5,x7` with rs1_ren = 1 → one cycle with pc/ifid wen = 0 and bubble = 1. The next cycle is clean. `o_cnt_bubble` = 1.
- **Load then store data**: EX `lw x5`; ID `sw x5,0(x8)` (rs2 = 5, st_en = 1) → bubble = 0, `o_id_ldstbp` = 1, all wen = 1. With `sw x9,0(x5)` instead → bubble = 1 and ldstbp = 0.
- **x0 and non-load**: EX `lw x0`, or EX `add x5` with ld_en = 0, while ID reads x5 → no bubble.
- **Redirect plus load-use**: jump = 1 and lu = 1 in the same cycle → flush = 1, bubble = 1, all wen = 1. `o_cnt_flush` = 1 and `o_cnt_bubble` = 0.
- **Busy stall with pending jump**: busy for 3 cycles while jump = 1 → 3 cycles with all wen = 0 and flush = 0. The flush follows in the cycle busy drops. `o_cnt_stall` = 3.
- **Watchdog**: TIMEOUT = 4, busy held for 4 cycles → `o_hang` = 1 after the 4th edge. It stays 1 and freeze stays held after busy drops. Asserting `rst_n` = 0 asynchronously clears it.
